// File: rtl/hba_pkg.sv
// hba_pkg: shared definitions for the HBA bus arbiter.
//   - hba_state_e : grant state machine encoding (IDLE, BUSY)
//   - HBA_*_WIDTH : default bus field widths
//   - hba_clog2   : ceil(log2(value)), for sizing parameters
package hba_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hba_state_e;

    localparam int HBA_DBUS_WIDTH        = 8;
    localparam int HBA_PERIPH_ADDR_WIDTH = 4;
    localparam int HBA_REG_ADDR_WIDTH    = 8;

    function automatic int hba_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hba_rr_picker.sv
// hba_rr_picker: combinational round-robin winner selection.
//   req_i    : request vector, bit i = master i
//   last_i   : index of the most recent grant
//   winner_o : first requesting index after last_i, searching cyclically
//   valid_o  : high when any request is present
module hba_rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic [IDX_W-1:0]       winner_o,
    output logic                   valid_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after last_i is the final assignment and therefore the winner.
    always_comb begin
        winner_o = last_i;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = int'(last_i) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                winner_o = cand_idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin arbiter, bus mux and bus-timeout watchdog.
//   hba_clk, hba_reset      : clock, asynchronous active-low reset
//   master_request          : per-master bus request
//   hba_mgrant              : registered one-hot (or zero) grant
//   master_abus/rnw/select/dbus : packed per-master bus fields
//   hba_abus/rnw/select/dbus    : shared bus, granted master's fields
//   hba_xferack             : OR of slave acks
//   master_xferack          : slave ack OR timeout pulse, to masters
//   hba_timeout             : one-cycle pulse on forced termination
//   dbg_state_o             : grant state machine state, for observation
//
// Handshake: a master holds master_request high for as long as it owns
// the bus; a transfer runs while hba_select is high and completes on the
// cycle master_xferack is high. The grant is released on the edge that
// samples the owner's request low, and at least one idle cycle separates
// any two grants.
module hba_arbiter
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS       = 2,
    parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
    parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
    parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                              hba_clk,
    input  logic                              hba_reset,
    input  logic [NUM_MASTERS-1:0]            master_request,
    output logic [NUM_MASTERS-1:0]            hba_mgrant,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
    input  logic [NUM_MASTERS-1:0]            master_rnw,
    input  logic [NUM_MASTERS-1:0]            master_select,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
    output logic [ADDR_WIDTH-1:0]             hba_abus,
    output logic                              hba_rnw,
    output logic                              hba_select,
    output logic [DBUS_WIDTH-1:0]             hba_dbus,
    input  logic                              hba_xferack,
    output logic                              master_xferack,
    output logic                              hba_timeout,
    output hba_state_e                        dbg_state_o
);

    localparam int IDX_W = (hba_clog2(NUM_MASTERS) < 1) ? 1 : hba_clog2(NUM_MASTERS);
    localparam int CNT_W = hba_clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]       LAST_RESET = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0]       CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0   = NUM_MASTERS'(1);

    hba_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    hba_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i    (master_request),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // ---------------------------------------------------------------
    // Grant state machine
    // ---------------------------------------------------------------
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RESET;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = ONE_HOT0 << pick_idx;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                // Only the owner's request matters; dropping it releases
                // the bus even if its select is still high.
                if ((master_request & grant_q) == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign hba_mgrant  = grant_q;
    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------
    // Bus mux: AND-OR of each master's fields with its grant bit, so
    // everything is zero while no grant is held.
    // ---------------------------------------------------------------
    always_comb begin
        hba_abus   = '0;
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_dbus   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            hba_abus   = hba_abus   | (master_abus[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
            hba_rnw    = hba_rnw    | (master_rnw[i]    & grant_q[i]);
            hba_select = hba_select | (master_select[i] & grant_q[i]);
            hba_dbus   = hba_dbus   | (master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
        end
    end

    // ---------------------------------------------------------------
    // Watchdog: counts stalled select cycles. The edge that would bring
    // the count to TIMEOUT_CYCLES raises the pulse and restarts the
    // count instead. A real ack on that cycle takes the clear branch,
    // so no pulse is produced.
    // ---------------------------------------------------------------
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (hba_select && !hba_xferack) begin
            if (cnt_q == CNT_LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign hba_timeout    = timeout_q;
    assign master_xferack = hba_xferack | timeout_q;

endmodule

// File: tb/tb_hba_arbiter.sv
module tb_hba_arbiter;
  import hba_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int PAW = 4;
  localparam int RAW = 8;
  localparam int AW  = PAW + RAW;
  localparam int TO  = 4;

  logic            hba_clk = 1'b0;
  logic            hba_reset;
  logic [N-1:0]    master_request;
  logic [N-1:0]    hba_mgrant;
  logic [N*AW-1:0] master_abus;
  logic [N-1:0]    master_rnw;
  logic [N-1:0]    master_select;
  logic [N*DW-1:0] master_dbus;
  logic [AW-1:0]   hba_abus;
  logic            hba_rnw;
  logic            hba_select;
  logic [DW-1:0]   hba_dbus;
  logic            hba_xferack;
  logic            master_xferack;
  logic            hba_timeout;
  hba_state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  hba_arbiter #(
    .NUM_MASTERS       (N),
    .DBUS_WIDTH        (DW),
    .PERIPH_ADDR_WIDTH (PAW),
    .REG_ADDR_WIDTH    (RAW),
    .ADDR_WIDTH        (AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .hba_clk        (hba_clk),
    .hba_reset      (hba_reset),
    .master_request (master_request),
    .hba_mgrant     (hba_mgrant),
    .master_abus    (master_abus),
    .master_rnw     (master_rnw),
    .master_select  (master_select),
    .master_dbus    (master_dbus),
    .hba_abus       (hba_abus),
    .hba_rnw        (hba_rnw),
    .hba_select     (hba_select),
    .hba_dbus       (hba_dbus),
    .hba_xferack    (hba_xferack),
    .master_xferack (master_xferack),
    .hba_timeout    (hba_timeout),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset block
  always #5 hba_clk = ~hba_clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_time_limit: simulation did not finish within the time budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Reference model: who owns the bus and how long the bus has stalled.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_stall = 0;
  bit m_to    = 1'b0;
  int m_to_seen = 0;

  always @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = N - 1;
      m_stall = 0;
      m_to    = 1'b0;
    end else begin
      bit sel;
      bit found;
      sel = m_busy && master_select[m_owner];
      if (sel && !hba_xferack) begin
        m_stall = m_stall + 1;
        m_to = (m_stall == TO);
        if (m_to) begin
          m_stall = 0;
          m_to_seen++;
        end
      end else begin
        m_stall = 0;
        m_to = 1'b0;
      end
      if (m_busy) begin
        if (!master_request[m_owner]) m_busy = 1'b0;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && master_request[c]) begin
            found = 1'b1;
            m_owner = c;
            m_last = c;
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  // driver tasks
  task clear_inputs;
    master_request = '0;
    master_abus    = '0;
    master_rnw     = '0;
    master_select  = '0;
    master_dbus    = '0;
    hba_xferack    = 1'b0;
  endtask

  task pulse_reset;
    @(negedge hba_clk);
    hba_reset = 1'b0;
    @(negedge hba_clk);
    hba_reset = 1'b1;
  endtask

  task test_reset;
    logic [AW-1:0] exp_addr;
    clear_inputs();
    hba_reset = 1'b0;
    master_abus   = N*AW'($urandom) | 1;
    master_dbus   = N*DW'($urandom) | 1;
    master_rnw    = '1;
    master_select = '1;
    repeat (3) @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", hba_mgrant); end
    checks++; if (hba_abus !== '0) begin errors++; $display("FAIL reset_abus: got %h expected 0", hba_abus); end
    checks++; if (hba_select !== 1'b0 || hba_rnw !== 1'b0) begin errors++; $display("FAIL reset_sel_rnw: got %b%b expected 00", hba_select, hba_rnw); end
    checks++; if (hba_dbus !== '0) begin errors++; $display("FAIL reset_dbus: got %h expected 0", hba_dbus); end
    checks++; if (hba_timeout !== 1'b0 || master_xferack !== 1'b0) begin errors++; $display("FAIL reset_ack: got to=%b xack=%b expected 0 0", hba_timeout, master_xferack); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    master_select = 3'b101;
    hba_reset = 1'b1;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b000) begin errors++; $display("FAIL post_reset_grant: got %b expected 000", hba_mgrant); end
    master_request = 3'b010;
    @(negedge hba_clk);
    exp_addr = master_abus[AW +: AW];
    checks++; if (hba_mgrant !== 3'b010) begin errors++; $display("FAIL first_grant_m1: got %b expected 010", hba_mgrant); end
    checks++; if (hba_abus !== exp_addr) begin errors++; $display("FAIL first_grant_abus: got %h expected %h", hba_abus, exp_addr); end
    checks++; if (hba_select !== 1'b0) begin errors++; $display("FAIL foreign_select: got %b expected 0", hba_select); end
    master_request = '0;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b000) begin errors++; $display("FAIL release_m1: got %b expected 000", hba_mgrant); end
    clear_inputs();
  endtask

  task test_simultaneous;
    logic [N-1:0] exp_g;
    clear_inputs();
    pulse_reset();
    master_request = 3'b011;
    for (int g = 0; g < 4; g++) begin
      @(negedge hba_clk);
      exp_g = (g % 2 == 0) ? 3'b001 : 3'b010;
      checks++; if (hba_mgrant !== exp_g) begin errors++; $display("FAIL simul_grant%0d: got %b expected %b", g, hba_mgrant, exp_g); end
      master_request = master_request & ~exp_g;
      @(negedge hba_clk);
      checks++; if (hba_mgrant !== 3'b000) begin errors++; $display("FAIL simul_idle%0d: got %b expected 000", g, hba_mgrant); end
      master_request = 3'b011;
    end
    @(negedge hba_clk);
    clear_inputs();
    @(negedge hba_clk);
    @(negedge hba_clk);
  endtask

  task test_no_preempt;
    clear_inputs();
    pulse_reset();
    master_request = 3'b001;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b001) begin errors++; $display("FAIL np_grant0: got %b expected 001", hba_mgrant); end
    master_request = 3'b011;
    master_abus[0 +: AW] = 12'h001;
    master_abus[AW +: AW] = 12'hFFF;
    master_dbus[0 +: DW] = 8'hA5;
    master_dbus[DW +: DW] = 8'h5A;
    master_rnw = 3'b010;
    master_select = 3'b011;
    #1;
    checks++; if (hba_abus !== 12'h001) begin errors++; $display("FAIL np_abus: got %h expected 001", hba_abus); end
    checks++; if (hba_dbus !== 8'hA5) begin errors++; $display("FAIL np_dbus: got %h expected a5", hba_dbus); end
    checks++; if (hba_rnw !== 1'b0 || hba_select !== 1'b1) begin errors++; $display("FAIL np_rnw_sel: got rnw=%b sel=%b expected 0 1", hba_rnw, hba_select); end
    repeat (2) begin
      @(negedge hba_clk);
      checks++; if (hba_mgrant !== 3'b001) begin errors++; $display("FAIL np_hold: got %b expected 001", hba_mgrant); end
    end
    hba_xferack = 1'b1;
    #1;
    checks++; if (master_xferack !== 1'b1) begin errors++; $display("FAIL np_xack: got %b expected 1", master_xferack); end
    @(negedge hba_clk);
    hba_xferack = 1'b0;
    master_select = 3'b010;
    master_request = 3'b010;
    #1;
    checks++; if (master_xferack !== 1'b0 || hba_timeout !== 1'b0) begin errors++; $display("FAIL np_xack_end: got xack=%b to=%b expected 0 0", master_xferack, hba_timeout); end
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b000) begin errors++; $display("FAIL np_release: got %b expected 000", hba_mgrant); end
    master_select = 3'b000;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b010) begin errors++; $display("FAIL np_next_m1: got %b expected 010", hba_mgrant); end
    checks++; if (hba_abus !== 12'hFFF) begin errors++; $display("FAIL np_abus_m1: got %h expected fff", hba_abus); end
    clear_inputs();
    @(negedge hba_clk);
  endtask

  task test_timeout;
    int pulses;
    bit exp_to;
    clear_inputs();
    pulse_reset();
    master_request = 3'b001;
    @(negedge hba_clk);
    master_select = 3'b001;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge hba_clk);
      exp_to = (k == 4) || (k == 8);
      if (hba_timeout === 1'b1) pulses++;
      checks++; if (hba_timeout !== exp_to || master_xferack !== exp_to) begin errors++; $display("FAIL timeout_cycle%0d: got to=%b xack=%b expected %b", k, hba_timeout, master_xferack, exp_to); end
    end
    master_select = '0;
    @(negedge hba_clk);
    checks++; if (hba_timeout !== 1'b0) begin errors++; $display("FAIL timeout_after: got %b expected 0", hba_timeout); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL timeout_count: got %0d expected 2", pulses); end
    clear_inputs();
    @(negedge hba_clk);
  endtask

  task test_ack_on_limit;
    clear_inputs();
    pulse_reset();
    master_request = 3'b001;
    @(negedge hba_clk);
    master_select = 3'b001;
    repeat (3) begin
      @(negedge hba_clk);
      checks++; if (hba_timeout !== 1'b0) begin errors++; $display("FAIL aol_pre: got %b expected 0", hba_timeout); end
    end
    hba_xferack = 1'b1;
    #1;
    checks++; if (master_xferack !== 1'b1 || hba_timeout !== 1'b0) begin errors++; $display("FAIL aol_ack: got xack=%b to=%b expected 1 0", master_xferack, hba_timeout); end
    @(negedge hba_clk);
    hba_xferack = 1'b0;
    #1;
    checks++; if (master_xferack !== 1'b0 || hba_timeout !== 1'b0) begin errors++; $display("FAIL aol_no_pulse: got xack=%b to=%b expected 0 0", master_xferack, hba_timeout); end
    repeat (3) begin
      @(negedge hba_clk);
      checks++; if (hba_timeout !== 1'b0) begin errors++; $display("FAIL aol_restart: got %b expected 0", hba_timeout); end
    end
    clear_inputs();
    @(negedge hba_clk);
    @(negedge hba_clk);
  endtask

  task test_async_reset;
    clear_inputs();
    pulse_reset();
    master_request = 3'b001;
    master_select  = 3'b001;
    master_abus    = N*AW'($urandom) | 1;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b001 || hba_select !== 1'b1) begin errors++; $display("FAIL ar_busy: got grant=%b sel=%b expected 001 1", hba_mgrant, hba_select); end
    @(posedge hba_clk);
    #2;
    hba_reset = 1'b0;
    #1;
    checks++; if (hba_mgrant !== 3'b000 || hba_select !== 1'b0) begin errors++; $display("FAIL ar_drop: got grant=%b sel=%b expected 000 0", hba_mgrant, hba_select); end
    checks++; if (hba_abus !== '0 || master_xferack !== 1'b0 || hba_timeout !== 1'b0) begin errors++; $display("FAIL ar_bus: got abus=%h xack=%b to=%b expected 0", hba_abus, master_xferack, hba_timeout); end
    master_select  = '0;
    master_request = 3'b011;
    @(negedge hba_clk);
    hba_reset = 1'b1;
    @(negedge hba_clk);
    checks++; if (hba_mgrant !== 3'b001) begin errors++; $display("FAIL ar_priority: got %b expected 001", hba_mgrant); end
    clear_inputs();
    @(negedge hba_clk);
    @(negedge hba_clk);
  endtask

  task test_random;
    logic [N-1:0]  e_grant;
    logic [AW-1:0] e_abus;
    logic [DW-1:0] e_dbus;
    logic          e_rnw, e_sel, e_xack;
    clear_inputs();
    pulse_reset();
    m_to_seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge hba_clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) master_request[i] = ~master_request[i];
        master_select[i] = ($urandom_range(0, 3) != 0);
      end
      master_abus = {$urandom, $urandom};
      master_dbus = N*DW'($urandom);
      master_rnw  = N'($urandom);
      hba_xferack = ($urandom_range(0, 7) == 0);
      #1;
      e_grant = m_busy ? (N'(1) << m_owner) : '0;
      e_abus  = m_busy ? master_abus[m_owner*AW +: AW] : '0;
      e_dbus  = m_busy ? master_dbus[m_owner*DW +: DW] : '0;
      e_rnw   = m_busy ? master_rnw[m_owner] : 1'b0;
      e_sel   = m_busy ? master_select[m_owner] : 1'b0;
      e_xack  = hba_xferack | m_to;
      checks++; if (hba_mgrant !== e_grant) begin errors++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, hba_mgrant, e_grant); end
      checks++; if (hba_abus !== e_abus || hba_dbus !== e_dbus) begin errors++; $display("FAIL rnd_data c%0d: got %h/%h expected %h/%h", c, hba_abus, hba_dbus, e_abus, e_dbus); end
      checks++; if (hba_rnw !== e_rnw || hba_select !== e_sel) begin errors++; $display("FAIL rnd_ctrl c%0d: got rnw=%b sel=%b expected %b %b", c, hba_rnw, hba_select, e_rnw, e_sel); end
      checks++; if (hba_timeout !== m_to || master_xferack !== e_xack) begin errors++; $display("FAIL rnd_ack c%0d: got to=%b xack=%b expected %b %b", c, hba_timeout, master_xferack, m_to, e_xack); end
    end
    checks++; if (m_to_seen == 0) begin errors++; $display("FAIL rnd_timeout_coverage: got %0d timeouts expected >0", m_to_seen); end
    clear_inputs();
    @(negedge hba_clk);
  endtask

  initial begin
    hba_reset = 1'b0;
    clear_inputs();
    test_reset();
    test_simultaneous();
    test_no_preempt();
    test_timeout();
    test_ack_on_limit();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
